// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch queue feeding the Fetch stage: runs sequential word fetches
// ahead of the pipeline and flushes stale entries/in-flight fetches on redirect.
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RedirectF,
  input  logic [31:0] RedirectPCF,
  input  logic        AdvanceF,
  output logic [31:0] InstrF,
  output logic [31:0] InstrPCF,
  output logic        InstrValidF,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t      state, state_next;
  logic [AW:0] wptr, rptr, count, count_next;
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] fetch_addr, fetch_addr_next;
  logic [31:0] addr_q, addr_next;
  logic        req_q, fire, outstanding, push, pop, valid;

  assign count       = wptr - rptr;
  assign valid       = (count != '0);
  assign fire        = req_q & IMemAck;
  assign outstanding = req_q & ~IMemAck;
  assign push        = fire & (state == FETCH) & ~RedirectF;
  assign pop         = AdvanceF & valid & ~RedirectF;
  assign count_next  = RedirectF ? '0 : (count + (AW+1)'(push) - (AW+1)'(pop));

  // Redirect wins over everything; a still-pending request must drain through DISCARD.
  always_comb begin
    state_next      = state;
    fetch_addr_next = fetch_addr;
    if (RedirectF) begin
      fetch_addr_next = {RedirectPCF[31:2], 2'b00};
      state_next      = outstanding ? DISCARD : FETCH;
    end else begin
      if (push) fetch_addr_next = fetch_addr + 32'd4;
      case (state)
        IDLE:    if (count_next != FULL) state_next = FETCH;
        FETCH:   if (count_next == FULL) state_next = IDLE;
        DISCARD: if (fire) state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end
    addr_next = outstanding ? addr_q : fetch_addr_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      wptr       <= '0;
      rptr       <= '0;
      fetch_addr <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state      <= state_next;
      fetch_addr <= fetch_addr_next;
      req_q      <= (state_next != IDLE);
      addr_q     <= addr_next;
      if (push) wptr <= wptr + 1'b1;
      if (RedirectF) rptr <= wptr;
      else if (pop) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wptr[AW-1:0]] <= IMemRData;
      pc_mem[wptr[AW-1:0]]    <= fetch_addr;
    end
  end

  assign InstrValidF = valid;
  assign InstrF      = valid ? instr_mem[rptr[AW-1:0]] : '0;
  assign InstrPCF    = valid ? pc_mem[rptr[AW-1:0]] : '0;
  assign IMemReq     = req_q;
  assign IMemAddr    = addr_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with a variable-latency memory that
// returns data equal to the request address.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        RedirectF;
  logic [31:0] RedirectPCF;
  logic        AdvanceF;
  logic [31:0] InstrF, InstrPCF, IMemAddr, IMemRData;
  logic        InstrValidF, IMemReq, IMemAck;

  int mem_wait = 0;
  int wait_cnt;
  int numCompared = 0;
  int numMismatched = 0;
  int acks;
  bit found;

  instr_prefetch_buffer dut (
    .clk(clk), .reset(reset),
    .RedirectF(RedirectF), .RedirectPCF(RedirectPCF), .AdvanceF(AdvanceF),
    .InstrF(InstrF), .InstrPCF(InstrPCF), .InstrValidF(InstrValidF),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemRData(IMemRData)
  );

  always #5 clk = ~clk;

  // Memory acks in the (mem_wait+1)-th cycle of each request.
  assign IMemAck   = IMemReq && (wait_cnt >= mem_wait);
  assign IMemRData = IMemAddr;

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (IMemReq && !IMemAck) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Inputs are applied at a falling edge and the bench returns at the next one.
  task automatic applyStimulus(input logic adv, input logic redir, input logic [31:0] tgt);
    AdvanceF    = adv;
    RedirectF   = redir;
    RedirectPCF = tgt;
    @(negedge clk);
  endtask

  task automatic doReset(input int lat);
    reset       = 1'b1;
    mem_wait    = lat;
    AdvanceF    = 1'b0;
    RedirectF   = 1'b0;
    RedirectPCF = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(InstrValidF), 32'd0);
    checkOutput("rst_req", 32'(IMemReq), 32'd0);
    checkOutput("rst_addr", IMemAddr, 32'd0);
    checkOutput("rst_instr", InstrF, 32'd0);
    checkOutput("rst_pc", InstrPCF, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Streaming with zero-wait memory and a always-advancing pipeline
    doReset(0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("s_req_c1", 32'(IMemReq), 32'd1);
    checkOutput("s_addr_c1", IMemAddr, 32'h0);
    checkOutput("s_valid_c1", 32'(InstrValidF), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("s_valid", 32'(InstrValidF), 32'd1);
      checkOutput("s_instr", InstrF, 32'(4 * i));
      checkOutput("s_pc", InstrPCF, 32'(4 * i));
    end

    // Fill to full with the pipeline stalled, then release one slot
    doReset(0);
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (IMemReq && IMemAck) acks++;
    end
    checkOutput("f_acks", 32'(acks), 32'd4);
    checkOutput("f_req_full", 32'(IMemReq), 32'd0);
    checkOutput("f_valid_full", 32'(InstrValidF), 32'd1);
    checkOutput("f_pc_head", InstrPCF, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("f_req_after_pop", 32'(IMemReq), 32'd1);
    checkOutput("f_addr_after_pop", IMemAddr, 32'd16);
    checkOutput("f_pc_after_pop", InstrPCF, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("f_req_refull", 32'(IMemReq), 32'd0);
    checkOutput("f_instr_refull", InstrF, 32'h4);

    // Redirect while a slow request is outstanding goes through DISCARD
    doReset(2);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (IMemReq && IMemAddr == 32'h8) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput("d_found_req8", 32'(found), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h100);
    checkOutput("d_req_held", 32'(IMemReq), 32'd1);
    checkOutput("d_addr_held", IMemAddr, 32'h8);
    checkOutput("d_valid_flushed", 32'(InstrValidF), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("d_addr_target", IMemAddr, 32'h100);
    checkOutput("d_valid_dropped", 32'(InstrValidF), 32'd0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (InstrValidF) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput("d_found_valid", 32'(found), 32'd1);
    checkOutput("d_first_pc", InstrPCF, 32'h100);
    checkOutput("d_first_instr", InstrF, 32'h100);

    // Redirect coinciding with an ack while two entries are queued
    doReset(0);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("r_valid_pre", 32'(InstrValidF), 32'd1);
    checkOutput("r_addr_pre", IMemAddr, 32'h8);
    checkOutput("r_ack_pre", 32'(IMemAck), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h40);
    checkOutput("r_valid_flushed", 32'(InstrValidF), 32'd0);
    checkOutput("r_addr_target", IMemAddr, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("r_first_pc", InstrPCF, 32'h40);
    checkOutput("r_first_instr", InstrF, 32'h40);

    // Unaligned target near the top of the address space wraps to zero
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE);
    checkOutput("w_addr_top", IMemAddr, 32'hFFFF_FFFC);
    checkOutput("w_valid", 32'(InstrValidF), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("w_addr_wrap", IMemAddr, 32'h0);
    checkOutput("w_pc_top", InstrPCF, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("w_pc_wrap", InstrPCF, 32'h0);

    // Asynchronous reset while a 5-cycle request is outstanding
    doReset(4);
    acks = 0;
    for (int c = 0; c < 40 && acks < 3; c++) begin
      if (IMemReq && IMemAck) acks++;
      applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput("a_acks", 32'(acks), 32'd3);
    checkOutput("a_valid_pre", 32'(InstrValidF), 32'd1);
    checkOutput("a_addr_pre", IMemAddr, 32'hC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    #2 reset = 1'b1;
    #1;
    checkOutput("a_valid_async", 32'(InstrValidF), 32'd0);
    checkOutput("a_req_async", 32'(IMemReq), 32'd0);
    checkOutput("a_addr_async", IMemAddr, 32'd0);
    checkOutput("a_instr_async", InstrF, 32'd0);
    checkOutput("a_pc_async", InstrPCF, 32'd0);
    @(negedge clk);
    doReset(4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("a_req_restart", 32'(IMemReq), 32'd1);
    checkOutput("a_addr_restart", IMemAddr, 32'h0);
    checkOutput("a_valid_restart", 32'(InstrValidF), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
